// File: rtl/ct_spsram_2048x32_req_ctrl.sv
// Request controller for a 2048x32 single-port SRAM macro.
// Optional zero-fill on reset: CT_SPSRAM_REQ_CTRL_INIT_EN.
`timescale 1ns/1ps
module ct_spsram_2048x32_req_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;

  logic                  run;
  logic                  hs;
  logic                  pop;
  logic                  push;
  logic                  rd_acc;
  logic                  full;
  logic                  empty;
  logic                  init_wr;
  logic [ADDR_WIDTH-1:0] init_a;

  logic                  cen_q, cen_d;
  logic                  gwen_q, gwen_d;
  logic [DATA_WIDTH-1:0] wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] d_q, d_d;

  logic                  rd_p1_q, rd_p1_d;
  logic                  rd_p2_q, rd_p2_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_d [RSP_DEPTH];
  logic [CW-1:0]         wptr_q, wptr_d;
  logic [CW-1:0]         rptr_q, rptr_d;

`ifdef CT_SPSRAM_REQ_CTRL_INIT_EN
  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
  logic                  init_fin_q, init_fin_d;

  // Zero-fill sweep: one write per cycle, then hand over to RUN.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    init_fin_d  = init_fin_q;
    if (state_q == ST_INIT) begin
      if (init_fin_q) begin
        state_d = ST_RUN;
      end else if (init_addr_q == '1) begin
        init_fin_d = 1'b1;
      end else begin
        init_addr_d = init_addr_q + 1'b1;
      end
    end
  end

  // Init state register.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      init_fin_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      init_fin_q  <= init_fin_d;
    end
  end

  assign run     = (state_q == ST_RUN);
  assign init_wr = (state_q == ST_INIT) & ~init_fin_q;
  assign init_a  = init_addr_q;
`else
  assign run     = 1'b1;
  assign init_wr = 1'b0;
  assign init_a  = '0;
`endif

  assign rsp_vld   = ~empty;
  assign pop       = rsp_vld & rsp_rdy;
  assign req_rdy   = run & ((cnt_q < CW'(RSP_DEPTH)) | pop);
  assign hs        = req_vld & req_rdy;
  assign rd_acc    = hs & ~req_wr;
  assign push      = rd_p2_q;
  assign init_done = run;

  // Next pin cycle: init write, accepted request, or idle hold.
  always_comb begin
    cen_d  = 1'b1;
    gwen_d = 1'b1;
    wen_d  = '1;
    a_d    = a_q;
    d_d    = d_q;
    if (init_wr) begin
      cen_d  = 1'b0;
      gwen_d = 1'b0;
      wen_d  = '0;
      a_d    = init_a;
      d_d    = '0;
    end else if (hs) begin
      cen_d = 1'b0;
      a_d   = req_addr;
      if (req_wr) begin
        gwen_d = 1'b0;
        wen_d  = ~req_wmask;
        d_d    = req_wdata;
      end
    end
  end

  // Pin registers, idle on reset.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      cen_q  <= 1'b1;
      gwen_q <= 1'b1;
      wen_q  <= '1;
      a_q    <= '0;
      d_q    <= '0;
    end else begin
      cen_q  <= cen_d;
      gwen_q <= gwen_d;
      wen_q  <= wen_d;
      a_q    <= a_d;
      d_q    <= d_d;
    end
  end

  assign sram_cen  = cen_q;
  assign sram_gwen = gwen_q;
  assign sram_wen  = wen_q;
  assign sram_a    = a_q;
  assign sram_d    = d_q;

  // Read tracking and credits (FIFO occupancy + reads in flight).
  always_comb begin
    rd_p1_d = rd_acc;
    rd_p2_d = rd_p1_q;
    cnt_d   = cnt_q + CW'(rd_acc) - CW'(pop);
  end

  // Read pipeline and credit counter.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_p1_q <= 1'b0;
      rd_p2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      rd_p1_q <= rd_p1_d;
      rd_p2_q <= rd_p2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PW] != rptr_q[PW]) &
                 (wptr_q[PW-1:0] == rptr_q[PW-1:0]);

  // Response FIFO update: capture Q on push, advance head on pop.
  always_comb begin
    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      fifo_d[wptr_q[PW-1:0]] = sram_q;
      wptr_d = wptr_q + CW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + CW'(1);
    end
  end

  // Response FIFO storage and pointers.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      fifo_q <= fifo_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  assign rsp_data = fifo_q[rptr_q[PW-1:0]];

  a_no_overflow: assert property (
    @(posedge forever_cpuclk) disable iff (!cpurst_b)
    !(push & full)
  );

endmodule

// File: tb/tb_ct_spsram_2048x32_req_ctrl.sv
// Scoreboard bench for the SRAM request controller.
// Behavioural SRAM + reference memory model.
`timescale 1ns/1ps
module tb_ct_spsram_2048x32_req_ctrl;

`ifdef CT_SPSRAM_REQ_CTRL_INIT_EN
  localparam bit INIT_EN  = 1'b1;
  localparam int INIT_CYC = 2049;
`else
  localparam bit INIT_EN  = 1'b0;
  localparam int INIT_CYC = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic        req_wr = 1'b0;
  logic [10:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_wmask = '0;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_data;
  logic        init_done;
  logic [10:0] sram_a;
  logic        sram_cen;
  logic        sram_gwen;
  logic [31:0] sram_wen;
  logic [31:0] sram_d;
  logic [31:0] sram_q = '0;

  bit rdy_mode = 1'b0;
  bit rdy_fix  = 1'b1;
  bit rdy_rnd  = 1'b1;
  assign rsp_rdy = rdy_mode ? rdy_rnd : rdy_fix;

  always #5 clk = ~clk;

  ct_spsram_2048x32_req_ctrl dut (
    .forever_cpuclk(clk),
    .cpurst_b      (rst_n),
    .req_vld       (req_vld),
    .req_rdy       (req_rdy),
    .req_wr        (req_wr),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wmask     (req_wmask),
    .rsp_vld       (rsp_vld),
    .rsp_rdy       (rsp_rdy),
    .rsp_data      (rsp_data),
    .init_done     (init_done),
    .sram_a        (sram_a),
    .sram_cen      (sram_cen),
    .sram_gwen     (sram_gwen),
    .sram_wen      (sram_wen),
    .sram_d        (sram_d),
    .sram_q        (sram_q)
  );

  logic [31:0] sram_mem [2048];
  logic [31:0] ref_mem  [2048];

  // SRAM macro: bit-masked write, registered read.
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen)
        sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) |
                            (sram_d & ~sram_wen);
      else
        sram_q <= sram_mem[sram_a];
    end
  end

  always @(posedge clk) begin
    #1;
    rdy_rnd = ($urandom_range(0, 3) != 0);
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endfunction

  logic [31:0] exp_q [$];
  int          acc_q [$];
  bit          mon_en = 1'b0;
  bit          have_exp = 1'b0;
  bit          head_seen = 1'b0;
  int          last_pop = 0;
  logic        exp_cen = 1'b1;
  logic        exp_gwen = 1'b1;
  logic [31:0] exp_wen = '1;
  logic [10:0] exp_a = '0;
  logic [31:0] exp_d = '0;

  // Monitor: pin expectations, response order, data and latency.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (have_exp) begin
        chk("pin_cen", 32'(sram_cen), 32'(exp_cen));
        chk("pin_gwen", 32'(sram_gwen), 32'(exp_gwen));
        chk("pin_wen", sram_wen, exp_wen);
        chk("pin_a", 32'(sram_a), 32'(exp_a));
        chk("pin_d", sram_d, exp_d);
      end
      if (rsp_vld) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL stale_rsp: got %h want none", rsp_data);
        end else begin
          if (!head_seen) begin
            int want;
            want = acc_q[0] + 3;
            if (last_pop + 1 > want) want = last_pop + 1;
            chk("rsp_latency", 32'(cyc), 32'(want));
            head_seen = 1'b1;
          end
          if (rsp_rdy) begin
            chk("rsp_data", rsp_data, exp_q[0]);
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            last_pop = cyc;
            head_seen = 1'b0;
          end
        end
      end
      exp_cen  = 1'b1;
      exp_gwen = 1'b1;
      exp_wen  = '1;
      if (req_vld && req_rdy) begin
        exp_cen = 1'b0;
        exp_a   = req_addr;
        if (req_wr) begin
          exp_gwen = 1'b0;
          exp_wen  = ~req_wmask;
          exp_d    = req_wdata;
          ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) |
                              (req_wdata & req_wmask);
        end else begin
          exp_q.push_back(ref_mem[req_addr]);
          acc_q.push_back(cyc);
        end
      end
      have_exp = 1'b1;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input bit wr, input logic [10:0] a,
                       input logic [31:0] d, input logic [31:0] m);
    int n;
    n = 0;
    req_vld   = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
    while (1) begin
      @(negedge clk);
      if (req_rdy) break;
      n++;
      if (n >= 64) begin
        n_cmp++;
        n_err++;
        $display("FAIL req_timeout: got no req_rdy want handshake");
        break;
      end
    end
    @(posedge clk);
    #1;
    req_vld = 1'b0;
  endtask

  task automatic do_reset();
    int n;
    int nwr;
    int bad_rdy;
    int bad_pin;
    mon_en  = 1'b0;
    req_vld = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("rst_cen", 32'(sram_cen), 32'd1);
    chk("rst_gwen", 32'(sram_gwen), 32'd1);
    chk("rst_wen", sram_wen, 32'hFFFF_FFFF);
    chk("rst_a", 32'(sram_a), 32'd0);
    chk("rst_d", sram_d, 32'd0);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    exp_q.delete();
    acc_q.delete();
    have_exp  = 1'b0;
    head_seen = 1'b0;
    last_pop  = 0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    nwr = 0;
    bad_rdy = 0;
    bad_pin = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (init_done) break;
      if (req_rdy) bad_rdy++;
      if (!sram_cen) begin
        if (!sram_gwen && sram_wen == '0 && sram_d == '0 &&
            sram_a == nwr[10:0])
          nwr++;
        else
          bad_pin++;
      end
      if (n > 2200) begin
        n_cmp++;
        n_err++;
        $display("FAIL init_timeout: got no init_done want done");
        break;
      end
    end
    chk("init_done_cycle", 32'(n), 32'(INIT_CYC));
    chk("init_rdy_low", 32'(bad_rdy), 32'd0);
    chk("init_writes", 32'(nwr), INIT_EN ? 32'd2048 : 32'd0);
    chk("init_bad_pins", 32'(bad_pin), 32'd0);
    chk("rdy_after_init", 32'(req_rdy), 32'd1);
    if (INIT_EN) begin
      for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
    end
    exp_a  = INIT_EN ? 11'h7FF : 11'h000;
    exp_d  = '0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops(input int n);
    for (int i = 0; i < n; i++) begin
      logic [10:0] a;
      logic [31:0] m;
      int sel;
      idle($urandom_range(0, 2));
      a = 11'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a = 11'h7F8 + a;
      sel = $urandom_range(0, 3);
      m = (sel == 0) ? 32'hFFFF_FFFF :
          (sel == 1) ? 32'h0 : $urandom;
      issue(1'($urandom_range(0, 1)), a, $urandom, m);
    end
  endtask

  initial begin
    int acc;
    int w;
    for (int i = 0; i < 2048; i++) begin
      if (INIT_EN) begin
        sram_mem[i] = $urandom | 32'h1;
        ref_mem[i]  = '0;
      end else begin
        sram_mem[i] = (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        ref_mem[i]  = (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
      end
    end
    #3;
    do_reset();

    issue(1'b1, 11'h005, 32'h1234_5678, 32'hFFFF_FFFF);
    issue(1'b0, 11'h005, 32'h0, 32'h0);
    idle(6);

    issue(1'b1, 11'h005, 32'hAAAA_AAAA, 32'h0000_FFFF);
    issue(1'b0, 11'h005, 32'h0, 32'h0);
    issue(1'b1, 11'h009, 32'hDEAD_BEEF, 32'h0);
    issue(1'b0, 11'h009, 32'h0, 32'h0);
    idle(6);

    rdy_fix = 1'b0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      req_vld  = 1'b1;
      req_wr   = 1'b0;
      req_addr = 11'(i * 3);
      @(negedge clk);
      if (req_rdy) acc++;
      @(posedge clk);
      #1;
    end
    req_vld = 1'b0;
    idle(3);
    chk("t3_accepted", 32'(acc), 32'd2);
    chk("t3_rdy_low", 32'(req_rdy), 32'd0);
    req_vld  = 1'b1;
    req_addr = 11'd6;
    rdy_fix  = 1'b1;
    @(negedge clk);
    chk("t3_rdy_on_pop", 32'(req_rdy), 32'd1);
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    idle(8);

    issue(1'b1, 11'h7FF, 32'hC0FF_EE11, 32'hFFFF_FFFF);
    issue(1'b0, 11'h7FF, 32'h0, 32'h0);
    idle(6);

    rdy_mode = 1'b1;
    rand_ops(300);
    rdy_mode = 1'b0;
    rdy_fix  = 1'b1;
    idle(8);

    issue(1'b0, 11'h001, 32'h0, 32'h0);
    issue(1'b0, 11'h002, 32'h0, 32'h0);
    #1;
    do_reset();

    rdy_mode = 1'b1;
    rand_ops(100);
    rdy_mode = 1'b0;
    rdy_fix  = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      idle(1);
      w++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
